// File: rtl/msrv32_dec.sv
// Main instruction decoder of the msrv32 RV32I core: classifies the opcode, checks the
// funct3 encoding and the load/store address alignment, and registers every control output.
module msrv32_dec (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [6:0] opcode_in,
  input  logic       funct7_5_in,
  input  logic [2:0] funct3_in,
  input  logic [1:0] iadder_1_to_0_in,
  input  logic       trap_taken_in,
  output logic [3:0] alu_opcode_out,
  output logic       mem_wr_req_out,
  output logic [1:0] load_size_out,
  output logic       load_unsigned_out,
  output logic       alu_src_out,
  output logic       iadder_src_out,
  output logic       csr_wr_en_out,
  output logic       rf_wr_en_out,
  output logic [2:0] wb_mux_sel_out,
  output logic [2:0] imm_type_out,
  output logic [2:0] csr_op_out,
  output logic       illegal_instr_out,
  output logic       misaligned_load_out,
  output logic       misaligned_store_out
);

  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;

  logic [3:0] alu_opcode_s;
  logic       alu_src_s;
  logic       iadder_src_s;
  logic       rf_wr_raw_s;
  logic       csr_wr_raw_s;
  logic [2:0] wb_mux_sel_s;
  logic [2:0] imm_type_s;
  logic       illegal_s;
  logic       is_load_s;
  logic       is_store_s;
  logic       mis_addr_s;
  logic       mis_load_s;
  logic       mis_store_s;
  logic       mem_wr_req_s;
  logic       rf_wr_en_s;
  logic       csr_wr_en_s;

  logic [3:0] alu_opcode_r;
  logic       mem_wr_req_r;
  logic [1:0] load_size_r;
  logic       load_unsigned_r;
  logic       alu_src_r;
  logic       iadder_src_r;
  logic       csr_wr_en_r;
  logic       rf_wr_en_r;
  logic [2:0] wb_mux_sel_r;
  logic [2:0] imm_type_r;
  logic [2:0] csr_op_r;
  logic       illegal_r;
  logic       mis_load_r;
  logic       mis_store_r;

  // Opcode class decode and per-class funct3 legality
  always_comb begin
    alu_opcode_s = 4'b0000;
    alu_src_s    = 1'b0;
    iadder_src_s = 1'b0;
    rf_wr_raw_s  = 1'b0;
    csr_wr_raw_s = 1'b0;
    wb_mux_sel_s = 3'b000;
    imm_type_s   = 3'b000;
    illegal_s    = 1'b0;
    is_load_s    = 1'b0;
    is_store_s   = 1'b0;
    if (opcode_in[1:0] != 2'b11) begin
      illegal_s = 1'b1;
    end else begin
      case (opcode_in[6:2])
        OPC_OP: begin
          alu_opcode_s = {funct7_5_in, funct3_in};
          alu_src_s    = 1'b1;
          rf_wr_raw_s  = 1'b1;
        end
        OPC_OP_IMM: begin
          // funct7_5 only selects SRAI vs SRLI; other immediates reuse that bit as data
          alu_opcode_s = {((funct3_in == 3'b101) ? funct7_5_in : 1'b0), funct3_in};
          rf_wr_raw_s  = 1'b1;
          imm_type_s   = 3'b001;
        end
        OPC_LOAD: begin
          is_load_s    = 1'b1;
          iadder_src_s = 1'b1;
          rf_wr_raw_s  = 1'b1;
          wb_mux_sel_s = 3'b001;
          imm_type_s   = 3'b001;
          illegal_s    = (funct3_in == 3'b011) || (funct3_in == 3'b110) || (funct3_in == 3'b111);
        end
        OPC_STORE: begin
          is_store_s   = 1'b1;
          iadder_src_s = 1'b1;
          imm_type_s   = 3'b010;
          illegal_s    = (funct3_in > 3'b010);
        end
        OPC_BRANCH: begin
          imm_type_s = 3'b011;
          illegal_s  = (funct3_in == 3'b010) || (funct3_in == 3'b011);
        end
        OPC_JAL: begin
          rf_wr_raw_s  = 1'b1;
          wb_mux_sel_s = 3'b101;
          imm_type_s   = 3'b101;
        end
        OPC_JALR: begin
          iadder_src_s = 1'b1;
          rf_wr_raw_s  = 1'b1;
          wb_mux_sel_s = 3'b101;
          imm_type_s   = 3'b001;
          illegal_s    = (funct3_in != 3'b000);
        end
        OPC_LUI: begin
          rf_wr_raw_s  = 1'b1;
          wb_mux_sel_s = 3'b010;
          imm_type_s   = 3'b100;
        end
        OPC_AUIPC: begin
          rf_wr_raw_s  = 1'b1;
          wb_mux_sel_s = 3'b011;
          imm_type_s   = 3'b100;
        end
        OPC_SYSTEM: begin
          rf_wr_raw_s  = (funct3_in != 3'b000);
          csr_wr_raw_s = (funct3_in != 3'b000) && (funct3_in != 3'b100);
          wb_mux_sel_s = 3'b100;
          imm_type_s   = 3'b110;
          illegal_s    = (funct3_in == 3'b100);
        end
        OPC_MISC_MEM: begin
          illegal_s = 1'b0;
        end
        default: begin
          illegal_s = 1'b1;
        end
      endcase
    end
  end

  // Alignment check and gating of the side-effecting enables
  always_comb begin
    if (funct3_in[1:0] == 2'b01) begin
      mis_addr_s = iadder_1_to_0_in[0];
    end else if (funct3_in[1:0] == 2'b10) begin
      mis_addr_s = (iadder_1_to_0_in != 2'b00);
    end else begin
      mis_addr_s = 1'b0;
    end
    mis_load_s   = is_load_s & mis_addr_s;
    mis_store_s  = is_store_s & mis_addr_s;
    mem_wr_req_s = is_store_s & ~mis_store_s & ~trap_taken_in & ~illegal_s;
    rf_wr_en_s   = rf_wr_raw_s & ~illegal_s;
    csr_wr_en_s  = csr_wr_raw_s & ~illegal_s;
  end

  // Output register stage
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      alu_opcode_r    <= 4'b0000;
      mem_wr_req_r    <= 1'b0;
      load_size_r     <= 2'b00;
      load_unsigned_r <= 1'b0;
      alu_src_r       <= 1'b0;
      iadder_src_r    <= 1'b0;
      csr_wr_en_r     <= 1'b0;
      rf_wr_en_r      <= 1'b0;
      wb_mux_sel_r    <= 3'b000;
      imm_type_r      <= 3'b000;
      csr_op_r        <= 3'b000;
      illegal_r       <= 1'b0;
      mis_load_r      <= 1'b0;
      mis_store_r     <= 1'b0;
    end else begin
      alu_opcode_r    <= alu_opcode_s;
      mem_wr_req_r    <= mem_wr_req_s;
      load_size_r     <= funct3_in[1:0];
      load_unsigned_r <= funct3_in[2];
      alu_src_r       <= alu_src_s;
      iadder_src_r    <= iadder_src_s;
      csr_wr_en_r     <= csr_wr_en_s;
      rf_wr_en_r      <= rf_wr_en_s;
      wb_mux_sel_r    <= wb_mux_sel_s;
      imm_type_r      <= imm_type_s;
      csr_op_r        <= funct3_in;
      illegal_r       <= illegal_s;
      mis_load_r      <= mis_load_s;
      mis_store_r     <= mis_store_s;
    end
  end

  assign alu_opcode_out       = alu_opcode_r;
  assign mem_wr_req_out       = mem_wr_req_r;
  assign load_size_out        = load_size_r;
  assign load_unsigned_out    = load_unsigned_r;
  assign alu_src_out          = alu_src_r;
  assign iadder_src_out       = iadder_src_r;
  assign csr_wr_en_out        = csr_wr_en_r;
  assign rf_wr_en_out         = rf_wr_en_r;
  assign wb_mux_sel_out       = wb_mux_sel_r;
  assign imm_type_out         = imm_type_r;
  assign csr_op_out           = csr_op_r;
  assign illegal_instr_out    = illegal_r;
  assign misaligned_load_out  = mis_load_r;
  assign misaligned_store_out = mis_store_r;

endmodule

// File: tb/tb_msrv32_dec.sv
// Randomized self-checking bench for msrv32_dec against a table-driven decode model.
module tb_msrv32_dec;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [6:0] opcode_in = 7'd0;
  logic       funct7_5_in = 1'b0;
  logic [2:0] funct3_in = 3'd0;
  logic [1:0] iadder_1_to_0_in = 2'd0;
  logic       trap_taken_in = 1'b0;
  logic [3:0] alu_opcode_out;
  logic       mem_wr_req_out;
  logic [1:0] load_size_out;
  logic       load_unsigned_out;
  logic       alu_src_out;
  logic       iadder_src_out;
  logic       csr_wr_en_out;
  logic       rf_wr_en_out;
  logic [2:0] wb_mux_sel_out;
  logic [2:0] imm_type_out;
  logic [2:0] csr_op_out;
  logic       illegal_instr_out;
  logic       misaligned_load_out;
  logic       misaligned_store_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] alu;
    logic       mem;
    logic [1:0] size;
    logic       uns;
    logic       alu_src;
    logic       iad_src;
    logic       csr_wr;
    logic       rf_wr;
    logic [2:0] wb;
    logic [2:0] imm;
    logic [2:0] csr_op;
    logic       ill;
    logic       mld;
    logic       mst;
  } dec_t;

  msrv32_dec dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .opcode_in(opcode_in),
    .funct7_5_in(funct7_5_in), .funct3_in(funct3_in),
    .iadder_1_to_0_in(iadder_1_to_0_in), .trap_taken_in(trap_taken_in),
    .alu_opcode_out(alu_opcode_out), .mem_wr_req_out(mem_wr_req_out),
    .load_size_out(load_size_out), .load_unsigned_out(load_unsigned_out),
    .alu_src_out(alu_src_out), .iadder_src_out(iadder_src_out),
    .csr_wr_en_out(csr_wr_en_out), .rf_wr_en_out(rf_wr_en_out),
    .wb_mux_sel_out(wb_mux_sel_out), .imm_type_out(imm_type_out),
    .csr_op_out(csr_op_out), .illegal_instr_out(illegal_instr_out),
    .misaligned_load_out(misaligned_load_out), .misaligned_store_out(misaligned_store_out)
  );

  always #5 clk_in = ~clk_in;

  dec_t got_s;
  assign got_s = '{alu: alu_opcode_out, mem: mem_wr_req_out, size: load_size_out,
                   uns: load_unsigned_out, alu_src: alu_src_out, iad_src: iadder_src_out,
                   csr_wr: csr_wr_en_out, rf_wr: rf_wr_en_out, wb: wb_mux_sel_out,
                   imm: imm_type_out, csr_op: csr_op_out, ill: illegal_instr_out,
                   mld: misaligned_load_out, mst: misaligned_store_out};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (op=%b f3=%b f7_5=%b addr=%b trap=%b)",
               tag, obs, exp, opcode_in, funct3_in, funct7_5_in, iadder_1_to_0_in, trap_taken_in);
    end
  endtask

  // Reference decode: written from the instruction-class rules.
  function automatic dec_t model(input logic [6:0] op, input logic f75, input logic [2:0] f3,
                                 input logic [1:0] addr, input logic trap);
    dec_t d;
    int cls;
    bit ok, known, is_op, is_opi, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_aui, is_sys, is_fence;
    int sz;
    bit mis;
    d = '0;
    ok = (op[1:0] == 2'b11);
    cls = int'(op[6:2]);
    is_op    = ok && cls == 12;  is_opi  = ok && cls == 4;
    is_ld    = ok && cls == 0;   is_st   = ok && cls == 8;
    is_br    = ok && cls == 24;  is_jal  = ok && cls == 27;
    is_jalr  = ok && cls == 25;  is_lui  = ok && cls == 13;
    is_aui   = ok && cls == 5;   is_sys  = ok && cls == 28;
    is_fence = ok && cls == 3;
    known = is_op | is_opi | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_aui | is_sys | is_fence;
    d.ill = !known || (is_ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (is_st && f3 > 2) ||
            (is_br && (f3 == 2 || f3 == 3)) || (is_jalr && f3 != 0) || (is_sys && f3 == 4);
    if (is_op) d.alu = {f75, f3};
    else if (is_opi) d.alu = (f3 == 5) ? {f75, f3} : {1'b0, f3};
    d.alu_src = is_op;
    d.iad_src = is_ld | is_st | is_jalr;
    d.rf_wr = !d.ill && (is_op | is_opi | is_ld | is_lui | is_aui | is_jal | is_jalr | (is_sys && f3 != 0));
    d.csr_wr = !d.ill && is_sys && f3 != 0 && f3 != 4;
    d.wb = is_ld ? 3'd1 : is_lui ? 3'd2 : is_aui ? 3'd3 : is_sys ? 3'd4 : (is_jal | is_jalr) ? 3'd5 : 3'd0;
    d.imm = is_st ? 3'd2 : is_br ? 3'd3 : (is_lui | is_aui) ? 3'd4 : is_jal ? 3'd5 : is_sys ? 3'd6 :
            (is_opi | is_ld | is_jalr) ? 3'd1 : 3'd0;
    sz = int'(f3) % 4;
    mis = (sz == 1 && (addr % 2) != 0) || (sz == 2 && addr != 0);
    d.mld = is_ld && mis;
    d.mst = is_st && mis;
    d.mem = is_st && !mis && !trap && !d.ill;
    d.size = f3[1:0];
    d.uns = f3[2];
    d.csr_op = f3;
    return d;
  endfunction

  task automatic check_all(input dec_t e);
    check("alu_opcode", 32'(got_s.alu), 32'(e.alu));
    check("mem_wr_req", 32'(got_s.mem), 32'(e.mem));
    check("load_size", 32'(got_s.size), 32'(e.size));
    check("load_unsigned", 32'(got_s.uns), 32'(e.uns));
    check("alu_src", 32'(got_s.alu_src), 32'(e.alu_src));
    check("iadder_src", 32'(got_s.iad_src), 32'(e.iad_src));
    check("csr_wr_en", 32'(got_s.csr_wr), 32'(e.csr_wr));
    check("rf_wr_en", 32'(got_s.rf_wr), 32'(e.rf_wr));
    check("wb_mux_sel", 32'(got_s.wb), 32'(e.wb));
    check("imm_type", 32'(got_s.imm), 32'(e.imm));
    check("csr_op", 32'(got_s.csr_op), 32'(e.csr_op));
    check("illegal", 32'(got_s.ill), 32'(e.ill));
    check("mis_load", 32'(got_s.mld), 32'(e.mld));
    check("mis_store", 32'(got_s.mst), 32'(e.mst));
  endtask

  // Drive one instruction, clock it in, and compare everything against the model.
  task automatic apply(input logic [6:0] op, input logic f75, input logic [2:0] f3,
                       input logic [1:0] addr, input logic trap);
    opcode_in = op; funct7_5_in = f75; funct3_in = f3;
    iadder_1_to_0_in = addr; trap_taken_in = trap;
    @(posedge clk_in);
    #1;
    check_all(model(op, f75, f3, addr, trap));
  endtask

  logic [6:0] legal_ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011,
                                 7'b0001111};

  initial begin
    logic [6:0] op;
    // Reset state
    opcode_in = 7'b0110111;
    #12;
    check("reset_all_zero", 32'(got_s), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Directed cases
    apply(7'b0110111, 1'b0, 3'b000, 2'b00, 1'b0);
    check("lui_rf_wr", 32'(rf_wr_en_out), 32'd1);
    check("lui_wb", 32'(wb_mux_sel_out), 32'd2);
    check("lui_imm", 32'(imm_type_out), 32'd4);
    apply(7'b1100011, 1'b0, 3'b001, 2'b01, 1'b1);
    check("bne_imm", 32'(imm_type_out), 32'd3);
    check("bne_illegal", 32'(illegal_instr_out), 32'd0);
    apply(7'b0000011, 1'b0, 3'b100, 2'b10, 1'b0);
    check("lbu_unsigned", 32'(load_unsigned_out), 32'd1);
    check("lbu_wb", 32'(wb_mux_sel_out), 32'd1);
    check("lbu_misaligned", 32'(misaligned_load_out), 32'd0);
    apply(7'b0100011, 1'b0, 3'b010, 2'b00, 1'b0);
    check("sw_mem_wr", 32'(mem_wr_req_out), 32'd1);
    apply(7'b0100011, 1'b0, 3'b010, 2'b10, 1'b0);
    check("sw_mis_store", 32'(misaligned_store_out), 32'd1);
    check("sw_mis_no_wr", 32'(mem_wr_req_out), 32'd0);
    apply(7'b0100011, 1'b0, 3'b010, 2'b00, 1'b1);
    check("sw_trap_no_wr", 32'(mem_wr_req_out), 32'd0);
    apply(7'b0110011, 1'b1, 3'b000, 2'b00, 1'b0);
    check("sub_alu", 32'(alu_opcode_out), 32'd8);
    check("sub_alu_src", 32'(alu_src_out), 32'd1);
    apply(7'b1111111, 1'b0, 3'b000, 2'b00, 1'b0);
    check("bad_op_illegal", 32'(illegal_instr_out), 32'd1);
    check("bad_op_rf_wr", 32'(rf_wr_en_out), 32'd0);
    apply(7'b0010011, 1'b1, 3'b101, 2'b00, 1'b0);
    check("srai_alu", 32'(alu_opcode_out), 32'd13);
    apply(7'b0010011, 1'b1, 3'b000, 2'b00, 1'b0);
    check("addi_alu", 32'(alu_opcode_out), 32'd0);
    apply(7'b1110011, 1'b0, 3'b001, 2'b00, 1'b0);
    check("csrrw_csr_wr", 32'(csr_wr_en_out), 32'd1);

    // Asynchronous reset mid-stream, then decode resumes on the first edge
    #1;
    rst_n_in = 1'b0;
    #1;
    check("midreset_zero", 32'(got_s), 32'd0);
    #2;
    rst_n_in = 1'b1;
    apply(7'b0110111, 1'b0, 3'b000, 2'b00, 1'b0);
    check("post_reset_wb", 32'(wb_mux_sel_out), 32'd2);

    // Randomized sweep, mostly recognised opcodes, some raw noise
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 10)];
      else op = 7'($urandom);
      apply(op, 1'($urandom), 3'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
